// File: rtl/bcd_countdown_chain.sv
// Multi-digit BCD down-counter with per-digit wrap values, internal borrow chain,
// optional hold-at-zero and a registered terminal pulse on reaching zero.
module bcd_countdown_chain #(
   parameter int                  DIGITS       = 4,
   parameter logic [4*DIGITS-1:0] WRAP_MAX     = 16'h9959,
   parameter bit                  HOLD_AT_ZERO = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  enable_n,
   output logic [4*DIGITS-1:0]   count,
   output logic                  zero,
   output logic [DIGITS-1:0]     borrow_n,
   output logic                  done
);

   logic [DIGITS-1:0]   low_zero;
   logic [DIGITS-1:0]   borrow_in;
   logic [4*DIGITS-1:0] dec_val;
   logic [4*DIGITS-1:0] load_clamped;

   // low_zero[i]: digits 0..i all zero; borrow_in[i]: digits below i all zero.
   always_comb begin
      logic run;
      low_zero  = '0;
      borrow_in = '0;
      run       = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         borrow_in[i] = run;
         run          = run & (count[4*i +: 4] == 4'd0);
         low_zero[i]  = run;
      end
   end

   assign borrow_n = ~low_zero;
   assign zero     = low_zero[DIGITS-1];

   // Out-of-range digits simply step down by one; only a zero digit takes its wrap value.
   always_comb begin
      logic [3:0] v;
      dec_val = count;
      for (int i = 0; i < DIGITS; i++) begin
         v = count[4*i +: 4];
         if (borrow_in[i]) begin
            if (v == 4'd0) dec_val[4*i +: 4] = WRAP_MAX[4*i +: 4];
            else           dec_val[4*i +: 4] = v - 4'd1;
         end
      end
   end

   always_comb begin
      logic [3:0] n;
      load_clamped = '0;
      for (int i = 0; i < DIGITS; i++) begin
         n = load_val[4*i +: 4];
         load_clamped[4*i +: 4] = (n > 4'd9) ? 4'd9 : n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         done  <= 1'b0;
      end else if (load) begin
         count <= load_clamped;
         done  <= 1'b0;
      end else if (!enable_n) begin
         if (zero) begin
            if (!HOLD_AT_ZERO) count <= WRAP_MAX;
            done <= 1'b0;
         end else begin
            count <= dec_val;
            done  <= (dec_val == '0);
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_countdown_chain.sv
// Scoreboard bench: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_bcd_countdown_chain;

   logic        clk = 1'b0;
   logic        rst, load, enable_n;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        zero, done;
   logic [3:0]  borrow_n;

   logic        rst2, load2, en2_n;
   logic [7:0]  load_val2;
   logic [7:0]  count2;
   logic        zero2, done2;
   logic [1:0]  borrow_n2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          sel;
      logic [15:0] cnt;
      logic        dn;
      string       name;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   bcd_countdown_chain dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .enable_n(enable_n),
      .count(count), .zero(zero), .borrow_n(borrow_n), .done(done)
   );

   bcd_countdown_chain #(.DIGITS(2), .WRAP_MAX(8'h59), .HOLD_AT_ZERO(1'b0)) dut2 (
      .clk(clk), .rst(rst2), .load(load2), .load_val(load_val2), .enable_n(en2_n),
      .count(count2), .zero(zero2), .borrow_n(borrow_n2), .done(done2)
   );

   function automatic logic [3:0] bn_of(input logic [15:0] c, input int nd);
      logic [3:0] r;
      logic run;
      r   = 4'b1111;
      run = 1'b1;
      for (int i = 0; i < nd; i++) begin
         run  = run & (c[4*i +: 4] == 4'd0);
         r[i] = ~run;
      end
      return r;
   endfunction

   function automatic logic [15:0] bcd2(input int n);
      logic [3:0] t, u;
      t = 4'(n / 10);
      u = 4'(n % 10);
      return {8'h00, t, u};
   endfunction

   task automatic check(input string nm, input string what, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s %s: got %h expected %h", nm, what, act, exp);
      end
   endtask

   task automatic cyc(input bit sel, input logic r, input logic ld, input logic [15:0] lv,
                      input logic en_n, input logic [15:0] ec, input logic ed, input string nm);
      exp_t e;
      @(negedge clk);
      if (!sel) begin
         rst = r; load = ld; load_val = lv; enable_n = en_n;
      end else begin
         rst2 = r; load2 = ld; load_val2 = lv[7:0]; en2_n = en_n;
      end
      e.sel = sel; e.cnt = ec; e.dn = ed; e.name = nm;
      q.push_back(e);
   endtask

   // Monitor: count/done settle right after each edge, so sample 2 time units later.
   initial begin
      exp_t e;
      logic [15:0] a_cnt;
      logic        a_zero, a_done;
      logic [3:0]  a_bn;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) begin
               a_cnt = {8'h00, count2}; a_zero = zero2; a_done = done2; a_bn = {2'b11, borrow_n2};
            end else begin
               a_cnt = count; a_zero = zero; a_done = done; a_bn = borrow_n;
            end
            check(e.name, "count", a_cnt, e.cnt);
            check(e.name, "zero", {15'd0, a_zero}, {15'd0, e.cnt == 16'h0000});
            check(e.name, "done", {15'd0, a_done}, {15'd0, e.dn});
            check(e.name, "borrow_n", {12'd0, a_bn}, {12'd0, bn_of(e.cnt, e.sel ? 2 : 4)});
         end
      end
   end

   initial begin
      rst = 1'b0; load = 1'b1; load_val = 16'h1234; enable_n = 1'b1;
      rst2 = 1'b0; load2 = 1'b0; load_val2 = 8'h00; en2_n = 1'b1;

      cyc(0, 0, 1, 16'h1234, 1, 16'h0000, 0, "reset_edge1");
      cyc(0, 0, 1, 16'h1234, 1, 16'h0000, 0, "reset_edge2");
      cyc(0, 1, 1, 16'h1234, 1, 16'h1234, 0, "load_1234");

      cyc(0, 1, 1, 16'h0100, 1, 16'h0100, 0, "load_0100");
      cyc(0, 1, 0, 16'h0000, 0, 16'h0059, 0, "borrow_0100");
      cyc(0, 1, 0, 16'h0000, 0, 16'h0058, 0, "dec_0059");
      cyc(0, 1, 0, 16'h0000, 1, 16'h0058, 0, "hold_0058");
      cyc(0, 1, 1, 16'h1000, 1, 16'h1000, 0, "load_1000");
      cyc(0, 1, 0, 16'h0000, 0, 16'h0959, 0, "borrow_1000");

      cyc(0, 1, 1, 16'h0075, 1, 16'h0075, 0, "load_0075");
      for (int k = 1; k <= 75; k++)
         cyc(0, 1, 0, 16'h0000, 0, bcd2(75 - k), (k == 75), $sformatf("oor_step%0d", k));
      for (int k = 0; k < 3; k++)
         cyc(0, 1, 0, 16'h0000, 0, 16'h0000, 0, $sformatf("hold_zero%0d", k));

      cyc(0, 1, 1, 16'h0AFF, 1, 16'h0999, 0, "clamp_0AFF");
      cyc(0, 1, 0, 16'h0000, 0, 16'h0998, 0, "clamp_dec");

      cyc(0, 1, 1, 16'h0001, 1, 16'h0001, 0, "load_0001");
      cyc(0, 1, 1, 16'h0030, 0, 16'h0030, 0, "load_beats_en");
      cyc(0, 1, 0, 16'h0000, 0, 16'h0029, 0, "dec_0030");
      cyc(0, 0, 0, 16'h0000, 0, 16'h0000, 0, "rst_midcount");
      cyc(0, 1, 1, 16'h0001, 1, 16'h0001, 0, "load_0001b");
      cyc(0, 1, 0, 16'h0000, 0, 16'h0000, 1, "done_pulse");
      cyc(0, 1, 1, 16'h0000, 0, 16'h0000, 0, "load_zero_done");
      cyc(0, 1, 0, 16'h0000, 1, 16'h0000, 0, "idle");

      cyc(1, 0, 0, 16'h0000, 1, 16'h0000, 0, "w_reset");
      cyc(1, 1, 1, 16'h0001, 1, 16'h0001, 0, "w_load01");
      cyc(1, 1, 0, 16'h0000, 0, 16'h0000, 1, "w_to_zero");
      cyc(1, 1, 0, 16'h0000, 0, 16'h0059, 0, "w_wrap");
      cyc(1, 1, 0, 16'h0000, 0, 16'h0058, 0, "w_dec");

      @(posedge clk);
      #5;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
